// File: rtl/alu_cmd_sequencer.sv
// Packet controller between UART and ALU: parses SOF/OP/A/B/CHK frames, checks the
// XOR checksum, drives the ALU operands and answers with ACK+result or NAK.
module alu_cmd_sequencer #(
  parameter int                 NB_DATA = 8,
  parameter int                 NB_OPS  = 6,
  parameter int                 ALU_LAT = 1,
  parameter int                 TIMEOUT = 10000,
  parameter logic [NB_DATA-1:0] SOF     = 8'hAA,
  parameter logic [NB_DATA-1:0] ACK     = 8'h06,
  parameter logic [NB_DATA-1:0] NAK     = 8'h15
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_res,
  input  logic               i_tx_ready,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OPS-1:0]  o_ops,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic [7:0]         o_err_cnt
);

  localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int LAT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [3:0] {
    IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_ACK, SEND_RES, SEND_NAK
  } state_t;

  state_t             state_reg, state_next;
  logic [NB_DATA-1:0] op_reg, op_next;
  logic [NB_DATA-1:0] a_reg, a_next;
  logic [NB_DATA-1:0] b_reg, b_next;
  logic [NB_DATA-1:0] res_reg, res_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
  logic [7:0]         err_cnt_reg, err_cnt_next;
  logic [NB_DATA-1:0] data_a_reg, data_a_next;
  logic [NB_DATA-1:0] data_b_reg, data_b_next;
  logic [NB_OPS-1:0]  ops_reg, ops_next;
  logic               tx_valid_reg, tx_valid_next;
  logic [NB_DATA-1:0] tx_data_reg, tx_data_next;
  logic               err_inc;
  logic               to_expired;

  assign to_expired = (to_cnt_reg == TO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      res_reg      <= '0;
      to_cnt_reg   <= '0;
      lat_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
      data_a_reg   <= '0;
      data_b_reg   <= '0;
      ops_reg      <= '0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      res_reg      <= res_next;
      to_cnt_reg   <= to_cnt_next;
      lat_cnt_reg  <= lat_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      data_a_reg   <= data_a_next;
      data_b_reg   <= data_b_next;
      ops_reg      <= ops_next;
      tx_valid_reg <= tx_valid_next;
      tx_data_reg  <= tx_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    res_next     = res_reg;
    to_cnt_next  = to_cnt_reg;
    lat_cnt_next = lat_cnt_reg;
    data_a_next  = data_a_reg;
    data_b_next  = data_b_reg;
    ops_next     = ops_reg;
    err_inc      = 1'b0;

    case (state_reg)
      IDLE: begin
        to_cnt_next  = '0;
        lat_cnt_next = '0;
        if (i_rx_valid && (i_rx_data == SOF)) state_next = GET_OP;
      end
      GET_OP, GET_A, GET_B: begin
        // An arriving byte takes priority over an expiring timeout.
        if (i_rx_valid) begin
          to_cnt_next = '0;
          case (state_reg)
            GET_OP:  begin op_next = i_rx_data; state_next = GET_A;   end
            GET_A:   begin a_next  = i_rx_data; state_next = GET_B;   end
            default: begin b_next  = i_rx_data; state_next = GET_CHK; end
          endcase
        end else if (to_expired) begin
          to_cnt_next = '0;
          err_inc     = 1'b1;
          state_next  = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      GET_CHK: begin
        if (i_rx_valid) begin
          to_cnt_next = '0;
          if (i_rx_data == (op_reg ^ a_reg ^ b_reg)) begin
            ops_next     = op_reg[NB_OPS-1:0];
            data_a_next  = a_reg;
            data_b_next  = b_reg;
            lat_cnt_next = '0;
            state_next   = EXEC;
          end else begin
            err_inc    = 1'b1;
            state_next = SEND_NAK;
          end
        end else if (to_expired) begin
          to_cnt_next = '0;
          err_inc     = 1'b1;
          state_next  = IDLE;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      EXEC: begin
        if (lat_cnt_reg == LAT_W'(ALU_LAT - 1)) begin
          res_next     = i_res;
          lat_cnt_next = '0;
          state_next   = SEND_ACK;
        end else begin
          lat_cnt_next = lat_cnt_reg + LAT_W'(1);
        end
      end
      SEND_ACK: if (i_tx_ready) state_next = SEND_RES;
      SEND_RES: if (i_tx_ready) state_next = IDLE;
      SEND_NAK: if (i_tx_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_inc && (err_cnt_reg != 8'hFF)) err_cnt_next = err_cnt_reg + 8'd1;
  end

  // TX outputs are registered from the next state so they are stable while waiting for ready.
  always_comb begin
    tx_valid_next = 1'b0;
    tx_data_next  = '0;
    case (state_next)
      SEND_ACK: begin tx_valid_next = 1'b1; tx_data_next = ACK;      end
      SEND_RES: begin tx_valid_next = 1'b1; tx_data_next = res_next; end
      SEND_NAK: begin tx_valid_next = 1'b1; tx_data_next = NAK;      end
      default:  ;
    endcase
  end

  assign o_data_a   = data_a_reg;
  assign o_data_b   = data_b_reg;
  assign o_ops      = ops_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_tx_valid = tx_valid_reg;
  assign o_busy     = (state_reg != IDLE);
  assign o_err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: ALU modelled as A+B, TIMEOUT=16, ALU_LAT=1.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] res;
  logic       tx_ready;
  logic [7:0] data_a, data_b, tx_data, err_cnt;
  logic [5:0] ops;
  logic       tx_valid, busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.ALU_LAT(1), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .i_res(res), .i_tx_ready(tx_ready), .o_data_a(data_a), .o_data_b(data_b),
    .o_ops(ops), .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_busy(busy),
    .o_err_cnt(err_cnt)
  );

  assign res = data_a + data_b;

  // Inputs change 1ns after posedge, so at negedge a valid&ready pair is an accept at the next edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] chk);
    send_byte(8'hAA);
    send_byte(op);
    send_byte(a);
    send_byte(b);
    send_byte(chk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_tx2(input string tag, input logic [7:0] b1);
    check({tag, "_txn"}, txq.size(), 2);
    if (txq.size() == 2) begin
      check({tag, "_tx0"}, txq[0], 8'h06);
      check({tag, "_tx1"}, txq[1], b1);
    end
  endtask

  initial begin
    int n;
    int stable;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",  busy, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_data",  tx_data, 0);
    check("rst_err",   err_cnt, 0);
    check("rst_opnd",  {ops, data_a, data_b}, 0);

    // Good packet: operands after CHK edge, ACK one cycle later, then A+B
    txq.delete();
    send_pkt(8'h20, 8'h05, 8'h03, 8'h26);
    check("good_ops", ops, 6'h20);
    check("good_a",   data_a, 8'h05);
    check("good_b",   data_b, 8'h03);
    check("good_lat0", tx_valid, 0);
    tick();
    check("good_ackv", {tx_valid, tx_data}, {1'b1, 8'h06});
    wait_idle("good");
    check_tx2("good", 8'h08);
    check("good_err", err_cnt, 0);

    // Bad checksum after reset: NAK only, operands untouched
    do_reset();
    txq.delete();
    send_pkt(8'h20, 8'h05, 8'h03, 8'h27);
    wait_idle("bad");
    check("bad_txn", txq.size(), 1);
    if (txq.size() == 1) check("bad_tx0", txq[0], 8'h15);
    check("bad_opnd", {ops, data_a, data_b}, 0);
    check("bad_err",  err_cnt, 1);

    // Backpressure: ACK held stable for 20 cycles with ready low
    txq.delete();
    tx_ready = 1'b0;
    send_pkt(8'h20, 8'h05, 8'h03, 8'h26);
    tick();
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'h06)) stable = 0;
      tick();
    end
    check("bp_stable", stable, 1);
    check("bp_none",   txq.size(), 0);
    tx_ready = 1'b1;
    wait_idle("bp");
    check_tx2("bp", 8'h08);

    // Timeout: AA,20 then silence returns to IDLE 16 cycles after the last byte
    do_reset();
    txq.delete();
    send_byte(8'hAA);
    send_byte(8'h20);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("to_cycles", n, 16);
    check("to_notx",   txq.size(), 0);
    check("to_err",    err_cnt, 1);
    send_pkt(8'h20, 8'h05, 8'h03, 8'h26);
    wait_idle("to_next");
    check_tx2("to_next", 8'h08);
    check("to_err2", err_cnt, 1);

    // Garbage before SOF, byte during SEND_ACK dropped
    txq.delete();
    tx_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_pkt(8'h01, 8'h0A, 8'h0B, 8'h00);
    n = 0;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    check("gb_ackv", {tx_valid, tx_data}, {1'b1, 8'h06});
    send_byte(8'h55);
    check("gb_hold", {tx_valid, tx_data}, {1'b1, 8'h06});
    tx_ready = 1'b1;
    wait_idle("gb");
    check_tx2("gb", 8'h15);
    check("gb_ops", ops, 6'h01);

    // Reset mid-packet, then a good packet
    txq.delete();
    send_byte(8'hAA);
    send_byte(8'h20);
    send_byte(8'h05);
    check("mid_busy", busy, 1);
    do_reset();
    check("mid_rst", {busy, tx_valid, tx_data, err_cnt, ops, data_a, data_b}, 0);
    send_pkt(8'h01, 8'h0A, 8'h0B, 8'h00);
    check("mid_opnd", {ops, data_a, data_b}, {6'h01, 8'h0A, 8'h0B});
    wait_idle("mid");
    check_tx2("mid", 8'h15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Packet-level controller between the UART receiver/transmitter and the ALU. It parses framed command packets (SOF, OP, A, B, CHK) from the RX byte stream and verifies an XOR checksum. A good packet is applied to the ALU, the block waits a fixed ALU latency, then returns ACK+result through a valid/ready TX handshake. A bad or timed-out packet is rejected, and an error counter is kept.

Parameters:
NB_DATA, 8, byte/operand width
NB_OPS, 6, ALU opcode width (low NB_OPS bits of OP byte)
ALU_LAT, 1, cycles from operand update to valid i_res (must be >=1)
TIMEOUT, 10000, max idle cycles between bytes inside a packet
SOF, 8'hAA, start-of-frame byte
ACK, 8'h06, status byte for good packet
NAK, 8'h15, status byte for checksum error

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_rx_data  in  NB_DATA  received byte
i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
i_res  in  NB_DATA  ALU result
i_tx_ready  in  1  transmitter can accept a byte this cycle
o_data_a  out  NB_DATA  ALU operand A
o_data_b  out  NB_DATA  ALU operand B
o_ops  out  NB_OPS  ALU opcode
o_tx_data  out  NB_DATA  byte to transmit
o_tx_valid  out  1  o_tx_data valid; held until accepted
o_busy  out  1  high in any state except IDLE
o_err_cnt  out  8  saturating count of checksum errors + timeouts

Behaviour:
- Reset: state IDLE; o_data_a/o_data_b/o_ops=0; o_tx_valid=0; o_tx_data=0; o_busy=0; o_err_cnt=0; staging regs, timeout and latency counters=0. Reset mid-packet or mid-transmit aborts immediately; no partial byte is sent afterwards.
- States: IDLE, GET_OP, GET_A, GET_B, GET_CHK, EXEC, SEND_ACK, SEND_RES, SEND_NAK.
- IDLE: rx byte == SOF -> GET_OP; any other byte is ignored.
- GET_OP/GET_A/GET_B: on i_rx_valid, store the byte in a staging reg, advance state. Byte values are not checked here; SOF is accepted as data.
- GET_CHK: on i_rx_valid, compare the byte against OP^A^B (full 8 bits).
  - Match: at the same edge load o_ops=OP[NB_OPS-1:0], o_data_a=A, o_data_b=B; go to EXEC.
  - Mismatch: operands unchanged; o_err_cnt++ (saturate at 255); go to SEND_NAK.
- Timeout: in GET_* states a counter clears on every i_rx_valid and on state entry, and increments otherwise. When it reaches TIMEOUT-1 with no byte that cycle: go to IDLE, o_err_cnt++, send nothing. If a byte arrives in the timeout cycle, the byte wins.
- EXEC: latency counter runs 0..ALU_LAT-1. At count ALU_LAT-1, capture i_res into the result reg and go to SEND_ACK. EXEC lasts exactly ALU_LAT cycles.
- SEND_ACK: o_tx_valid=1, o_tx_data=ACK. At an edge with i_tx_ready=1, go to SEND_RES.
- SEND_RES: o_tx_valid=1, o_tx_data=captured result. On ready, go to IDLE.
- SEND_NAK: o_tx_valid=1, o_tx_data=NAK. On ready, go to IDLE.
- o_tx_valid/o_tx_data are registered and stable while waiting for ready. o_tx_valid deasserts the cycle after the final accept. Back-to-back ACK/RES with ready held high gives two consecutive valid cycles.
- i_rx_valid during EXEC/SEND_*: the byte is dropped, with no state or counter effect. An SOF arriving in the same cycle that SEND_RES/SEND_NAK completes is also dropped.
- Operands hold their last good values indefinitely between packets.
- Latency, good packet with i_tx_ready=1: CHK accepted at edge T -> operands change after T -> o_tx_valid(ACK) rises after edge T+ALU_LAT -> result byte follows one cycle later.

Test Plan:
- Good packet AA,20,05,03,26 (ALU_LAT=1, i_res model = A+B): o_ops=6'h20, A=05, B=03 after CHK edge; TX sends 06 then 08; o_err_cnt=0; o_busy low afterwards.
- Bad checksum AA,20,05,03,27: TX sends 15 only; operands remain at the prior values (0 after reset); o_err_cnt=1.
- Backpressure: good packet with i_tx_ready low for 20 cycles: o_tx_valid=1 with o_tx_data=06 stable throughout; after ready rises, 06 then 08 are each accepted exactly once.
- Timeout: TIMEOUT=16, send AA,20 then silence: returns to IDLE 16 cycles after the last byte, no TX, o_err_cnt=1. The next full good packet is processed normally.
- Garbage/drop: bytes 11,22 before AA are ignored. A byte sent during SEND_ACK with ready=0 is dropped; the response stays 06,result.
- Reset mid-packet after AA,20,05: state returns to IDLE and all outputs return to reset values. A following good packet AA,01,0A,0B,00 yields o_ops=01, A=0A, B=0B and TX 06,result.
